// File: rtl/rvcpu_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package rvcpu_pkg;

  localparam int XLEN = 32;
  localparam int MULDIV_ITER = 32;
  localparam int MULDIV_LAT = 33;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage control and the muldiv unit.
interface muldiv_unit_if;
  import rvcpu_pkg::*;

  logic             start;
  logic             flush;
  muldiv_op_e       op;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;

  modport master (output start, flush, op, rs1_val, rs2_val,
                  input  busy, done, result);
  modport slave  (input  start, flush, op, rs1_val, rs2_val,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module muldiv_step
  import rvcpu_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (!is_div) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: 32 iterations on magnitudes, sign fix-up in FIX.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | one multiply/divide iteration per cycle
//   FIX   | sign correction, special-case override, result register
//   DONE  | done pulse; may accept the next start
module muldiv_unit
  import rvcpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITER - 1);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [4:0]        count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;

  logic              accept, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  // A flush in the same cycle as start discards the start.
  assign accept = (state_q == IDLE || state_q == DONE) && bus.start && !bus.flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (bus.flush) state_d = IDLE;
               else if (count_q == LAST_ITER) state_d = FIX;
      FIX:     state_d = bus.flush ? IDLE : DONE;
      DONE:    state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == CALC) || (state_q == FIX);
    bus.done = (state_q == DONE);
  end

  assign bus.result = result_q;

  always_comb begin
    sign_a = op_signed_a(bus.op) && bus.rs1_val[XLEN-1];
    sign_b = op_signed_b(bus.op) && bus.rs2_val[XLEN-1];
    mag_a  = sign_a ? -bus.rs1_val : bus.rs1_val;
    mag_b  = sign_b ? -bus.rs2_val : bus.rs2_val;
  end

  muldiv_step u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Divide by zero leaves the dividend magnitude in the remainder half, so
  // REM/REMU by zero fall out of the normal sign fix without an override.
  always_comb begin
    prod_fix   = neg_res_q ? -acc_q : acc_q;
    quo_fix    = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix    = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_result = quo_fix;
    case (op_q)
      OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:  fix_result = div_zero_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quo_fix);
      OP_DIVU: fix_result = div_zero_q ? '1 : quo_fix;
      OP_REM:  fix_result = ovf_q ? '0 : rem_fix;
      OP_REMU: fix_result = rem_fix;
      default: fix_result = quo_fix;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    if (accept) begin
      op_d       = bus.op;
      count_d    = '0;
      neg_res_d  = sign_a ^ sign_b;
      neg_rem_d  = sign_a;
      div_zero_d = bus.op[2] && (bus.rs2_val == '0);
      ovf_d      = (bus.op == OP_DIV || bus.op == OP_REM) &&
                   (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
      if (bus.op[2]) begin
        acc_d  = {{XLEN{1'b0}}, mag_a};
        opnd_d = mag_b;
      end else begin
        acc_d  = {{XLEN{1'b0}}, mag_b};
        opnd_d = mag_a;
      end
    end else if (state_q == CALC && !bus.flush) begin
      acc_d   = step_acc;
      count_d = count_q + 5'd1;
    end else if (state_q == FIX && !bus.flush) begin
      result_d = fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, random ops, handshake corners.
module tb_muldiv_unit;
  import rvcpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] last_exp;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11] = '{
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{3'd5, 32'd100,       32'd7,         32'd14},
    '{3'd7, 32'd100,       32'd7,         32'd2},
    '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,         32'd0,         32'd5},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
  };

  // Reference: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic scramble_inputs();
    logic [2:0] r;
    r = 3'($urandom_range(0, 7));
    bus.op      = muldiv_op_e'(r);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
  endtask

  // Presents a request so that it is sampled at the next rising edge (edge k);
  // returns 1 ns after edge k with the operands already scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = muldiv_op_e'(op);
    bus.rs1_val = a;
    bus.rs2_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_done(input int base, output int lat, output logic [31:0] res);
    lat = -1;
    res = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = base + i;
        res = bus.result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_basic();
    int busy_n, lat;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    busy_n = bus.busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin lat = i; break; end
      if (bus.busy) busy_n++;
    end
    n_cmp++; if (lat != MULDIV_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, MULDIV_LAT); end
    n_cmp++; if (busy_n != 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 33", busy_n); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_in_done: got %b want 0", bus.busy); end
    n_cmp++; if (bus.result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffeb", bus.result); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
    last_exp = 32'hFFFF_FFEB;
  endtask

  task automatic test_directed();
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, res);
      n_cmp++; if (lat != MULDIV_LAT) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, MULDIV_LAT); end
      n_cmp++; if (res !== vecs[i].exp) begin n_fail++; $display("FAIL directed_result[%0d] op=%0d: got %h want %h", i, vecs[i].op, res, vecs[i].exp); end
      last_exp = vecs[i].exp;
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a, b, res, exp;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp = ref_model(op, a, b);
      issue(op, a, b);
      wait_done(0, lat, res);
      n_cmp++; if (lat != MULDIV_LAT) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, MULDIV_LAT); end
      n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp); end
      last_exp = exp;
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    logic [31:0] a, b, exp1, exp2, res, res2;
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    exp1 = ref_model(3'd5, a, b);
    issue(3'd5, a, b);
    repeat (9) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.op      = OP_MUL;
    bus.rs1_val = ~a;
    bus.rs2_val = b + 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(10, lat, res);
    n_cmp++; if (lat != MULDIV_LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, MULDIV_LAT); end
    n_cmp++; if (res !== exp1) begin n_fail++; $display("FAIL b2b_first_result: got %h want %h", res, exp1); end
    a = $urandom;
    b = $urandom;
    exp2 = ref_model(3'd1, a, b);
    bus.start   = 1'b1;
    bus.op      = OP_MULH;
    bus.rs1_val = a;
    bus.rs2_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_in_done: got busy %b want 1", bus.busy); end
    wait_done(1, lat2, res2);
    n_cmp++; if (lat2 != MULDIV_LAT + 1) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d want %0d", lat2, MULDIV_LAT + 1); end
    n_cmp++; if (res2 !== exp2) begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", res2, exp2); end
    last_exp = exp2;
  endtask

  task automatic test_flush();
    int dones;
    issue(3'd3, $urandom, $urandom);
    repeat (14) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_to_idle: got busy %b want 0", bus.busy); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
    n_cmp++; if (bus.result !== last_exp) begin n_fail++; $display("FAIL flush_result_held: got %h want %h", bus.result, last_exp); end
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_DIVU;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_discards_start: got busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [31:0] a, b, exp, res;
    issue(3'd6, $urandom, $urandom);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h want 0 (prior %h)", bus.result, last_exp); end
    rst_n = 1'b1;
    a = $urandom;
    b = $urandom;
    exp = ref_model(3'd4, a, b);
    issue(3'd4, a, b);
    wait_done(0, lat, res);
    n_cmp++; if (lat != MULDIV_LAT) begin n_fail++; $display("FAIL post_reset_latency: got %0d want %0d", lat, MULDIV_LAT); end
    n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL post_reset_result: got %h want %h", res, exp); end
  endtask

  initial begin
    last_exp = '0;
    test_reset();
    test_mul_basic();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
